// File: rtl/dch_sweep_ctrl.sv
// dch_sweep_ctrl: sequences the dch up/down counter through a programmed number of
// lo->hi->lo sweeps, then parks it on lo.
//
// Ports
//   dsc_clk    clock, shared with dch
//   dsc_rst    synchronous active-high reset
//   dsc_start  one-cycle job request, only honoured in IDLE
//   dsc_abort  stop the current job and return to IDLE
//   dsc_lo     lower turn point (captured at start)
//   dsc_hi     upper turn point (captured at start)
//   dsc_n      number of full sweeps (captured at start)
//   dsc_q      current dch count (feedback)
//   dsc_en     dch enable
//   dsc_sel    dch direction, 1=up 0=down
//   dsc_busy   high whenever a job is in progress
//   dsc_done   registered one-cycle pulse on normal completion
//   dsc_err    registered one-cycle pulse on a rejected start
//   dsc_left   registered count of sweeps remaining, including the current one
module dch_sweep_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             dsc_clk,
    input  logic             dsc_rst,
    input  logic             dsc_start,
    input  logic             dsc_abort,
    input  logic [WIDTH-1:0] dsc_lo,
    input  logic [WIDTH-1:0] dsc_hi,
    input  logic [CNT_W-1:0] dsc_n,
    input  logic [WIDTH-1:0] dsc_q,
    output logic             dsc_en,
    output logic             dsc_sel,
    output logic             dsc_busy,
    output logic             dsc_done,
    output logic             dsc_err,
    output logic [CNT_W-1:0] dsc_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] hi_nxt;
    logic [CNT_W-1:0] left_nxt;
    logic             done_nxt;
    logic             err_nxt;

    // State and job registers; the sweep count itself lives in dsc_left.
    always_ff @(posedge dsc_clk) begin
        if (dsc_rst) begin
            state    <= IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            dsc_left <= '0;
            dsc_done <= 1'b0;
            dsc_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            lo_r     <= lo_nxt;
            hi_r     <= hi_nxt;
            dsc_left <= left_nxt;
            dsc_done <= done_nxt;
            dsc_err  <= err_nxt;
        end
    end

    // Next-state and counter-drive decode.
    always_comb begin
        state_nxt = state;
        lo_nxt    = lo_r;
        hi_nxt    = hi_r;
        left_nxt  = dsc_left;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        dsc_en    = 1'b0;
        dsc_sel   = 1'b1;

        case (state)
            IDLE: begin
                // abort in the same cycle suppresses a start
                if (dsc_start && !dsc_abort) begin
                    if ((dsc_lo < dsc_hi) && (dsc_n != '0)) begin
                        lo_nxt    = dsc_lo;
                        hi_nxt    = dsc_hi;
                        left_nxt  = dsc_n;
                        state_nxt = PRIME;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            PRIME: begin
                // walk straight toward lo in whichever direction avoids wrapping
                dsc_en  = (dsc_q != lo_r);
                dsc_sel = (dsc_q < lo_r);
                if (dsc_q == lo_r) begin
                    state_nxt = UP;
                end
            end
            UP: begin
                dsc_en  = 1'b1;
                dsc_sel = 1'b1;
                // turn on the edge that lands the counter on hi
                if (dsc_q == (hi_r - WIDTH'(1))) begin
                    state_nxt = DOWN;
                end
            end
            DOWN: begin
                dsc_en  = 1'b1;
                dsc_sel = 1'b0;
                // the edge that lands the counter on lo ends this sweep
                if (dsc_q == (lo_r + WIDTH'(1))) begin
                    if (dsc_left > CNT_W'(1)) begin
                        left_nxt  = dsc_left - CNT_W'(1);
                        state_nxt = UP;
                    end else begin
                        left_nxt  = '0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // abort leaves en/sel alone so at most the already-enabled step completes
        if (dsc_abort && (state != IDLE)) begin
            state_nxt = IDLE;
            left_nxt  = '0;
            done_nxt  = 1'b0;
        end
    end

    assign dsc_busy = (state != IDLE);

endmodule

// File: tb/tb_dch_sweep_ctrl.sv
// Bench for dch_sweep_ctrl: a behavioural dch counter closes the loop; a per-cycle
// trace queue and a done/err event queue are filled at stimulus time and drained by
// a monitor on the falling edge.
module tb_dch_sweep_ctrl;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             dsc_rst;
    logic             dsc_start;
    logic             dsc_abort;
    logic [WIDTH-1:0] dsc_lo;
    logic [WIDTH-1:0] dsc_hi;
    logic [CNT_W-1:0] dsc_n;
    logic [WIDTH-1:0] dsc_q;
    logic             dsc_en;
    logic             dsc_sel;
    logic             dsc_busy;
    logic             dsc_done;
    logic             dsc_err;
    logic [CNT_W-1:0] dsc_left;

    logic             q_load;
    logic [WIDTH-1:0] q_load_val;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [CNT_W-1:0] left;
        logic             en;
        logic             sel;
    } trace_t;

    typedef struct {
        bit               is_err;
        int               cyc;
        logic [WIDTH-1:0] q;
    } evt_t;

    trace_t trace_q[$];
    evt_t   evt_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural dch counter with a bench-side preload.
    always_ff @(posedge clk) begin
        if (q_load) dsc_q <= q_load_val;
        else if (dsc_en) dsc_q <= dsc_sel ? dsc_q + WIDTH'(1) : dsc_q - WIDTH'(1);
    end

    dch_sweep_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .dsc_clk   (clk),
        .dsc_rst   (dsc_rst),
        .dsc_start (dsc_start),
        .dsc_abort (dsc_abort),
        .dsc_lo    (dsc_lo),
        .dsc_hi    (dsc_hi),
        .dsc_n     (dsc_n),
        .dsc_q     (dsc_q),
        .dsc_en    (dsc_en),
        .dsc_sel   (dsc_sel),
        .dsc_busy  (dsc_busy),
        .dsc_done  (dsc_done),
        .dsc_err   (dsc_err),
        .dsc_left  (dsc_left)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Expected per-cycle trace of a job; the done latency is given by hand.
    function automatic void plan_job(input int q0, input int lo, input int hi, input int n,
                                     input int start_cyc, input int lat);
        int   q;
        int   left;
        evt_t e;
        q    = q0;
        left = n;
        while (q != lo) begin
            trace_q.push_back('{WIDTH'(q), CNT_W'(left), 1'b1, 1'(q < lo)});
            q = (q < lo) ? q + 1 : q - 1;
        end
        trace_q.push_back('{WIDTH'(lo), CNT_W'(left), 1'b0, 1'b0});
        for (int s = 0; s < n; s++) begin
            for (int k = lo; k < hi; k++) trace_q.push_back('{WIDTH'(k), CNT_W'(left), 1'b1, 1'b1});
            for (int k = hi; k > lo; k--) trace_q.push_back('{WIDTH'(k), CNT_W'(left), 1'b1, 1'b0});
            left--;
        end
        e.is_err = 1'b0;
        e.cyc    = start_cyc + lat;
        e.q      = WIDTH'(lo);
        evt_q.push_back(e);
    endfunction

    // Monitor: trace entry per busy cycle, event entry per done/err pulse.
    always @(negedge clk) begin
        trace_t t;
        evt_t   e;
        if (dsc_rst === 1'b0) begin
            if (dsc_busy === 1'b1) begin
                if (trace_q.size() == 0) flag("trace_unexpected_busy");
                else begin
                    t = trace_q.pop_front();
                    check("trace_q",    32'(dsc_q),    32'(t.q));
                    check("trace_left", 32'(dsc_left), 32'(t.left));
                    check("trace_en",   32'(dsc_en),   32'(t.en));
                    check("trace_sel",  32'(dsc_sel),  32'(t.sel));
                end
            end
            if (dsc_done === 1'b1 || dsc_err === 1'b1) begin
                if (evt_q.size() == 0) flag("evt_unexpected_pulse");
                else begin
                    e = evt_q.pop_front();
                    check("evt_err",  32'(dsc_err),  32'(e.is_err));
                    check("evt_done", 32'(dsc_done), 32'(!e.is_err));
                    check("evt_cycle", 32'(cyc), 32'(e.cyc));
                    check("evt_busy", 32'(dsc_busy), 32'(0));
                    if (!e.is_err) begin
                        check("done_q",    32'(dsc_q),    32'(e.q));
                        check("done_left", 32'(dsc_left), 32'(0));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_q(input int v);
        q_load     = 1'b1;
        q_load_val = WIDTH'(v);
        tick();
        q_load     = 1'b0;
    endtask

    task automatic start_job(input int q0, input int lo, input int hi, input int n, input int lat);
        load_q(q0);
        dsc_lo    = WIDTH'(lo);
        dsc_hi    = WIDTH'(hi);
        dsc_n     = CNT_W'(n);
        dsc_start = 1'b1;
        plan_job(q0, lo, hi, n, cyc, lat);
        tick();
        dsc_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (dsc_busy !== 1'b0 && k < max_cyc) begin
            tick();
            k++;
        end
        if (dsc_busy !== 1'b0) flag("wait_idle_timeout");
    endtask

    task automatic reject(input int lo, input int hi, input int n);
        evt_t e;
        dsc_lo    = WIDTH'(lo);
        dsc_hi    = WIDTH'(hi);
        dsc_n     = CNT_W'(n);
        dsc_start = 1'b1;
        e.is_err  = 1'b1;
        e.cyc     = cyc + 1;
        e.q       = '0;
        evt_q.push_back(e);
        tick();
        dsc_start = 1'b0;
        check("reject_busy", 32'(dsc_busy), 32'(0));
        check("reject_err",  32'(dsc_err),  32'(1));
        tick();
        check("reject_err_clear", 32'(dsc_err),  32'(0));
        check("reject_busy2",     32'(dsc_busy), 32'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"},   32'(dsc_en),   32'(0));
        check({tag, "_sel"},  32'(dsc_sel),  32'(1));
        check({tag, "_busy"}, 32'(dsc_busy), 32'(0));
        check({tag, "_done"}, 32'(dsc_done), 32'(0));
        check({tag, "_err"},  32'(dsc_err),  32'(0));
        check({tag, "_left"}, 32'(dsc_left), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        dsc_rst    = 1'b1;
        dsc_start  = 1'b0;
        dsc_abort  = 1'b0;
        dsc_lo     = '0;
        dsc_hi     = '0;
        dsc_n      = '0;
        q_load     = 1'b1;
        q_load_val = '0;
        tick();
        tick();
        check_reset_vals("reset");
        dsc_rst = 1'b0;
        q_load  = 1'b0;
        tick();

        // 0 -> 2 prime, one 2..5 sweep: 1 + 2 + 1 + 6 = 10 cycles
        start_job(0, 2, 5, 1, 10);
        check("job1_busy_after_start", 32'(dsc_busy), 32'(1));
        wait_idle(100);
        repeat (3) tick();
        check("job1_park_en", 32'(dsc_en), 32'(0));
        check("job1_park_q",  32'(dsc_q),  32'(2));

        // already on lo, three 3..4 sweeps: 1 + 0 + 1 + 6 = 8 cycles
        start_job(3, 3, 4, 3, 8);
        wait_idle(100);
        repeat (2) tick();
        check("job2_park_q", 32'(dsc_q), 32'(3));

        // prime downward from 12 to 1, one 1..6 sweep: 1 + 11 + 1 + 10 = 23 cycles
        start_job(12, 1, 6, 1, 23);
        wait_idle(100);
        repeat (2) tick();
        check("job3_park_q", 32'(dsc_q), 32'(1));

        // rejected starts
        reject(7, 7, 1);
        reject(2, 5, 0);
        reject(9, 3, 2);

        // abort in UP at q=4; a start while busy must be ignored
        start_job(1, 1, 9, 2, 40);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            dsc_start = (dsc_q == WIDTH'(2));
            if (dsc_start) begin
                dsc_lo = WIDTH'(0);
                dsc_hi = WIDTH'(3);
                dsc_n  = CNT_W'(1);
            end
            if (dsc_q == WIDTH'(4) && dsc_en && dsc_sel) hit = 1'b1;
        end
        dsc_start = 1'b0;
        if (!hit) flag("abort_reach_q4_timeout");
        dsc_abort = 1'b1;
        tick();
        dsc_abort = 1'b0;
        check("abort_busy", 32'(dsc_busy), 32'(0));
        check("abort_en",   32'(dsc_en),   32'(0));
        check("abort_q",    32'(dsc_q),    32'(5));
        check("abort_left", 32'(dsc_left), 32'(0));
        check("abort_done", 32'(dsc_done), 32'(0));
        trace_q.delete();
        evt_q.delete();
        repeat (3) tick();
        check("abort_hold_q", 32'(dsc_q), 32'(5));

        // reset in the middle of DOWN, then a clean job
        start_job(2, 2, 5, 2, 14);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (dsc_busy && dsc_en && !dsc_sel) hit = 1'b1;
        end
        if (!hit) flag("reset_reach_down_timeout");
        dsc_rst = 1'b1;
        tick();
        check_reset_vals("midreset");
        dsc_rst = 1'b0;
        trace_q.delete();
        evt_q.delete();
        tick();
        start_job(0, 2, 5, 1, 10);
        wait_idle(100);
        repeat (2) tick();
        check("restart_park_q", 32'(dsc_q), 32'(2));

        check("queues_drained", 32'(trace_q.size() + evt_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
